// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, synchronous clear/load, wrap or saturate at the
// boundary, one-cycle terminal-count pulse and sticky overflow flag.
module mod_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MODULUS  = 256,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] counter_o,
   output logic             tc_o,
   output logic             ovf_o
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PscLast = PW'(PRESCALE - 1);
   localparam logic [WIDTH:0] ModExt  = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH:0] MaxExt  = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH:0] OneExt  = (WIDTH + 1)'(1);

   if (WIDTH < 1) begin : g_bad_width
      $error("mod_counter: WIDTH must be >= 1");
   end
   if (MODULUS < 2 || (WIDTH < 32 && 64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
      $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $error("mod_counter: PRESCALE must be >= 1");
   end
   if (SATURATE > 1) begin : g_bad_saturate
      $error("mod_counter: SATURATE must be 0 or 1");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    psc_q, psc_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   cnt_ext, inc_ext, dec_ext, ld_ext;
   logic             step;

   // Extended arithmetic: inc hitting MODULUS or dec borrowing out marks the boundary.
   assign cnt_ext = {1'b0, cnt_q};
   assign inc_ext = cnt_ext + OneExt;
   assign dec_ext = cnt_ext - OneExt;
   assign ld_ext  = {1'b0, load_val_i};
   assign step    = en_i && (psc_q == PscLast);

   always_comb begin
      cnt_d = cnt_q;
      psc_d = psc_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         psc_d = '0;
         ovf_d = 1'b0;
      end else if (load_i) begin
         psc_d = '0;
         cnt_d = (ld_ext >= ModExt) ? MaxExt[WIDTH-1:0] : load_val_i;
      end else if (step) begin
         psc_d = '0;
         if (up_i) begin
            if (inc_ext == ModExt) begin
               cnt_d = (SATURATE != 0) ? cnt_q : '0;
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end else begin
               cnt_d = inc_ext[WIDTH-1:0];
            end
         end else begin
            if (dec_ext[WIDTH]) begin
               cnt_d = (SATURATE != 0) ? cnt_q : MaxExt[WIDTH-1:0];
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end else begin
               cnt_d = dec_ext[WIDTH-1:0];
            end
         end
      end else if (en_i) begin
         psc_d = psc_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         psc_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         psc_q <= psc_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign counter_o = cnt_q;
   assign tc_o      = tc_q;
   assign ovf_o     = ovf_q;

endmodule
